// File: rtl/bc_orbit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bc_orbit_sequencer
// Purpose  : Locks the bunch counter to the orbit marker, tracks orbit phase,
//            counts orbits, flags sync errors and generates a readout window.
// Revision : 1.0
// ============================================================================
module bc_orbit_sequencer #(
    parameter int BITS       = 12,
    parameter int ORBIT_LEN  = 3564,
    parameter int ORBIT_BITS = 16,
    parameter int WIN_START  = 0,
    parameter int WIN_LEN    = 16,
    parameter int MAX_ERR    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic                  i_bc0,
    output logic                  o_bc_rst,
    output logic [BITS-1:0]       o_phase,
    output logic [ORBIT_BITS-1:0] o_orbit,
    output logic                  o_locked,
    output logic                  o_window,
    output logic                  o_sync_err
);

    localparam int                 c_ERR_W     = $clog2(MAX_ERR + 1);
    localparam logic [BITS-1:0]    c_LAST      = BITS'(ORBIT_LEN - 1);
    localparam logic [BITS-1:0]    c_WIN_FIRST = BITS'(WIN_START);
    localparam logic [BITS:0]      c_WIN_LEN   = (BITS + 1)'(WIN_LEN);
    localparam logic [c_ERR_W-1:0] c_MAX_ERR   = c_ERR_W'(MAX_ERR);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_BC0 = 2'd1,
        S_LOCK     = 2'd2,
        S_LOST     = 2'd3
    } state_t;

    state_t                  r_state;
    logic [BITS-1:0]         r_phase;
    logic [ORBIT_BITS-1:0]   r_orbit;
    logic [c_ERR_W-1:0]      r_err_cnt;
    logic                    r_bc_rst;
    logic                    r_locked;
    logic                    r_window;
    logic                    r_sync_err;

    state_t                  w_state_nxt;
    logic [BITS-1:0]         w_phase_nxt;
    logic [ORBIT_BITS-1:0]   w_orbit_nxt;
    logic [c_ERR_W-1:0]      w_err_nxt;
    logic                    w_bc_rst_nxt;
    logic                    w_sync_err_nxt;
    logic                    w_window_nxt;
    logic                    w_wrap;
    logic                    w_fault;
    logic [c_ERR_W-1:0]      w_err_inc;
    logic [BITS-1:0]         w_win_off;

    assign w_wrap    = (r_phase == c_LAST);
    // Marker off the wrap phase is misaligned, no marker on it is missing.
    assign w_fault   = i_bc0 ^ w_wrap;
    assign w_err_inc = r_err_cnt + c_ERR_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = '0;
        w_orbit_nxt    = r_orbit;
        w_err_nxt      = r_err_cnt;
        w_bc_rst_nxt   = 1'b1;
        w_sync_err_nxt = 1'b0;
        if (!i_enable) begin
            w_state_nxt = S_IDLE;
            w_orbit_nxt = '0;
            w_err_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_WAIT_BC0;
                S_WAIT_BC0: begin
                    if (i_bc0) begin
                        w_state_nxt  = S_LOCK;
                        w_bc_rst_nxt = 1'b0;
                        w_orbit_nxt  = '0;
                        w_err_nxt    = '0;
                    end
                end
                S_LOCK: begin
                    w_phase_nxt  = w_wrap ? '0 : r_phase + BITS'(1);
                    w_orbit_nxt  = w_wrap ? r_orbit + ORBIT_BITS'(1) : r_orbit;
                    w_bc_rst_nxt = (w_phase_nxt == c_LAST);
                    if (w_fault) begin
                        w_sync_err_nxt = 1'b1;
                        w_err_nxt      = w_err_inc;
                        if (w_err_inc == c_MAX_ERR) begin
                            w_state_nxt  = S_LOST;
                            w_phase_nxt  = '0;
                            w_bc_rst_nxt = 1'b1;
                        end
                    end else if (w_wrap) begin
                        w_err_nxt = '0;
                    end
                end
                S_LOST:  w_state_nxt = S_WAIT_BC0;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Offset subtraction wraps below WIN_START, so one compare bounds both ends.
    assign w_win_off    = w_phase_nxt - c_WIN_FIRST;
    assign w_window_nxt = (w_state_nxt == S_LOCK) && ({1'b0, w_win_off} < c_WIN_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_orbit    <= '0;
            r_err_cnt  <= '0;
            r_bc_rst   <= 1'b1;
            r_locked   <= 1'b0;
            r_window   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_orbit    <= w_orbit_nxt;
            r_err_cnt  <= w_err_nxt;
            r_bc_rst   <= w_bc_rst_nxt;
            r_locked   <= (w_state_nxt == S_LOCK);
            r_window   <= w_window_nxt;
            r_sync_err <= w_sync_err_nxt;
        end
    end

    assign o_bc_rst   = r_bc_rst;
    assign o_phase    = r_phase;
    assign o_orbit    = r_orbit;
    assign o_locked   = r_locked;
    assign o_window   = r_window;
    assign o_sync_err = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_bc_orbit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bc_orbit_sequencer
// Purpose  : Directed self-checking bench for bc_orbit_sequencer.
// Revision : 1.0
// ============================================================================
module tb_bc_orbit_sequencer;

    localparam int c_LEN  = 3564;
    localparam int c_LAST = c_LEN - 1;
    localparam int c_WLEN = 16;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_bc0    = 1'b0;
    logic        o_bc_rst;
    logic [11:0] o_phase;
    logic [15:0] o_orbit;
    logic        o_locked;
    logic        o_window;
    logic        o_sync_err;

    int n_chk = 0;
    int n_err = 0;

    bc_orbit_sequencer #(
        .BITS       (12),
        .ORBIT_LEN  (c_LEN),
        .ORBIT_BITS (16),
        .WIN_START  (0),
        .WIN_LEN    (c_WLEN),
        .MAX_ERR    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_enable   (i_enable),
        .i_bc0      (i_bc0),
        .o_bc_rst   (o_bc_rst),
        .o_phase    (o_phase),
        .o_orbit    (o_orbit),
        .o_locked   (o_locked),
        .o_window   (o_window),
        .o_sync_err (o_sync_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one orbit starting at the phase-0 sample; stimulus and expectations
    // are indexed by the bench's own phase counter i.
    task automatic run_orbit(input bit marker, input int mis_at,
                             output int n_win, output int win_bad,
                             output int n_rst, output int rst_bad,
                             output int n_se, output int first_se,
                             output int ph_bad);
        n_win = 0; win_bad = 0; n_rst = 0; rst_bad = 0;
        n_se = 0; first_se = -1; ph_bad = 0;
        for (int i = 0; i < c_LEN; i++) begin
            if (o_window === 1'b1) n_win++;
            if (o_window !== (i < c_WLEN)) win_bad++;
            if (o_bc_rst === 1'b1) n_rst++;
            if (o_bc_rst !== (i == c_LAST)) rst_bad++;
            if (o_sync_err === 1'b1) begin
                n_se++;
                if (first_se < 0) first_se = i;
            end
            if (32'(o_phase) !== i) ph_bad++;
            i_bc0 = (marker && i == c_LAST) || (i == mis_at);
            tick();
        end
        i_bc0 = 1'b0;
    endtask

    initial begin
        int nw, wb, nr, rb, ns, fs, pb;
        int tot_w, tot_wb, tot_s;

        // Asynchronous reset, sampled before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bc_rst",  32'(o_bc_rst),   1);
        chk("rst_locked",  32'(o_locked),   0);
        chk("rst_phase",   32'(o_phase),    0);
        chk("rst_orbit",   32'(o_orbit),    0);
        chk("rst_window",  32'(o_window),   0);
        chk("rst_syncerr", 32'(o_sync_err), 0);
        tick(); tick();
        rst_n    = 1'b1;
        i_enable = 1'b1;

        // Acquire
        repeat (10) tick();
        chk("wait_locked", 32'(o_locked), 0);
        chk("wait_bc_rst", 32'(o_bc_rst), 1);
        i_bc0 = 1'b1;
        tick();
        i_bc0 = 1'b0;
        chk("acq_locked", 32'(o_locked), 1);
        chk("acq_phase",  32'(o_phase),  0);
        chk("acq_bc_rst", 32'(o_bc_rst), 0);
        chk("acq_orbit",  32'(o_orbit),  0);
        chk("acq_window", 32'(o_window), 1);

        run_orbit(1'b1, -1, nw, wb, nr, rb, ns, fs, pb);
        chk("orb1_phase_seq", pb, 0);
        chk("orb1_bcrst_cnt", nr, 1);
        chk("orb1_bcrst_pos", rb, 0);
        chk("orb1_win_cnt",   nw, c_WLEN);
        chk("orb1_win_pos",   wb, 0);
        chk("orb1_syncerr",   ns, 0);
        chk("wrap_phase",  32'(o_phase),  0);
        chk("wrap_orbit",  32'(o_orbit),  1);
        chk("wrap_bc_rst", 32'(o_bc_rst), 0);

        // Four more aligned orbits
        tot_w = 0; tot_wb = 0; tot_s = 0;
        repeat (4) begin
            run_orbit(1'b1, -1, nw, wb, nr, rb, ns, fs, pb);
            tot_w += nw; tot_wb += wb; tot_s += ns;
        end
        chk("al5_orbit",   32'(o_orbit), 5);
        chk("al5_win_cnt", tot_w, 4 * c_WLEN);
        chk("al5_win_pos", tot_wb, 0);
        chk("al5_syncerr", tot_s, 0);

        // Misaligned marker at phase 200
        run_orbit(1'b1, 200, nw, wb, nr, rb, ns, fs, pb);
        chk("mis_se_cnt",    ns, 1);
        chk("mis_se_phase",  fs, 201);
        chk("mis_phase_seq", pb, 0);
        chk("mis_locked",    32'(o_locked), 1);
        chk("mis_orbit",     32'(o_orbit),  6);

        // Three missing markers
        run_orbit(1'b0, -1, nw, wb, nr, rb, ns, fs, pb);
        chk("miss1_se_in",  ns, 0);
        chk("miss1_se",     32'(o_sync_err), 1);
        chk("miss1_locked", 32'(o_locked),   1);
        chk("miss1_orbit",  32'(o_orbit),    7);
        run_orbit(1'b0, -1, nw, wb, nr, rb, ns, fs, pb);
        chk("miss2_se",     32'(o_sync_err), 1);
        chk("miss2_locked", 32'(o_locked),   1);
        chk("miss2_orbit",  32'(o_orbit),    8);
        run_orbit(1'b0, -1, nw, wb, nr, rb, ns, fs, pb);
        chk("miss3_phase_seq", pb, 0);
        chk("lost_se",     32'(o_sync_err), 1);
        chk("lost_locked", 32'(o_locked),   0);
        chk("lost_bc_rst", 32'(o_bc_rst),   1);
        chk("lost_phase",  32'(o_phase),    0);
        chk("lost_window", 32'(o_window),   0);

        // Marker during LOST must be ignored
        i_bc0 = 1'b1;
        tick();
        i_bc0 = 1'b0;
        chk("wait2_locked", 32'(o_locked),   0);
        chk("wait2_bc_rst", 32'(o_bc_rst),   1);
        chk("wait2_se",     32'(o_sync_err), 0);
        repeat (3) tick();
        chk("wait3_locked", 32'(o_locked), 0);
        i_bc0 = 1'b1;
        tick();
        i_bc0 = 1'b0;
        chk("relock_locked", 32'(o_locked), 1);
        chk("relock_orbit",  32'(o_orbit),  0);
        chk("relock_phase",  32'(o_phase),  0);
        chk("relock_bc_rst", 32'(o_bc_rst), 0);

        // ENABLE drop coinciding with an aligned marker
        run_orbit(1'b1, -1, nw, wb, nr, rb, ns, fs, pb);
        chk("pre_dis_orbit", 32'(o_orbit), 1);
        repeat (c_LAST) tick();
        chk("pre_dis_phase", 32'(o_phase), c_LAST);
        i_enable = 1'b0;
        i_bc0    = 1'b1;
        tick();
        i_bc0 = 1'b0;
        chk("dis_locked", 32'(o_locked), 0);
        chk("dis_orbit",  32'(o_orbit),  0);
        chk("dis_phase",  32'(o_phase),  0);
        chk("dis_bc_rst", 32'(o_bc_rst), 1);
        chk("dis_window", 32'(o_window), 0);
        tick();
        chk("idle_locked", 32'(o_locked), 0);

        // Asynchronous reset mid-LOCK at phase 100
        i_enable = 1'b1;
        tick();
        i_bc0 = 1'b1;
        tick();
        i_bc0 = 1'b0;
        repeat (100) tick();
        chk("mid_phase",  32'(o_phase),  100);
        chk("mid_locked", 32'(o_locked), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bc_rst",  32'(o_bc_rst),   1);
        chk("arst_locked",  32'(o_locked),   0);
        chk("arst_phase",   32'(o_phase),    0);
        chk("arst_orbit",   32'(o_orbit),    0);
        chk("arst_window",  32'(o_window),   0);
        chk("arst_syncerr", 32'(o_sync_err), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
